// File: rtl/core_output_collector.sv
// core_output_collector
// Hardware sink for the multicore Taylor-network array. Each core presents a
// 4-bit enable code and a signed result; code 4'd1 marks a valid result. A
// valid result is parked in that core's holding register. A round-robin
// arbiter then moves one parked result per cycle, tagged with its core index,
// into a show-ahead FIFO. The FIFO drains through a valid/ready stream.
//
// Ports
//   clk, rst_n     system clock (rising edge), async active-low reset
//   out_en_bus     per-core enable code, slice i = [4*i+3:4*i]
//   io_out_bus     per-core result, slice i = [DATA_W*i+DATA_W-1:DATA_W*i]
//   m_data, m_id   FIFO head result and its core index
//   m_valid        FIFO not empty
//   m_ready        downstream accepts the head
//   fifo_level     FIFO occupancy
//   overrun        sticky per-core flag: a sample was dropped on that core
//   drop_count     total dropped samples, saturating
module core_output_collector #(
   parameter int N_CORES    = 33,
   parameter int DATA_W     = 28,
   parameter int ID_W       = 6,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [4*N_CORES-1:0]          out_en_bus,
   input  logic [DATA_W*N_CORES-1:0]     io_out_bus,
   output logic [DATA_W-1:0]             m_data,
   output logic [ID_W-1:0]               m_id,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [N_CORES-1:0]            overrun,
   output logic [15:0]                   drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ID_W + DATA_W;

   logic [N_CORES-1:0] pending_q, pending_d;
   logic [DATA_W-1:0]  hold_q [N_CORES];
   logic [DATA_W-1:0]  hold_d [N_CORES];
   logic [N_CORES-1:0] cap;
   logic [N_CORES-1:0] ovr;
   logic [N_CORES-1:0] gnt_oh;
   logic [N_CORES-1:0] overrun_q, overrun_d;
   logic [15:0]        drop_q, drop_d;

   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_vld;
   logic [ID_W:0]      cand;

   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ENT_W-1:0]   head;
   logic               push, pop, not_empty;

   logic [ID_W:0]      ovr_cnt;
   logic [16:0]        drop_sum;

   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         cap[i] = (out_en_bus[4*i +: 4] == 4'd1);
      end
   end

   // Cyclic priority search starting at rr_ptr. Walking the offsets from
   // high to low lets the smallest offset overwrite earlier hits. The FIFO
   // count before any pop gates the grant, so a full FIFO never grants.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(N_CORES)) begin
            cand = cand - (ID_W+1)'(N_CORES);
         end
         if (pending_q[cand[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[ID_W-1:0];
         end
      end
      if (count_q >= CNT_W'(FIFO_DEPTH)) begin
         gnt_vld = 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         gnt_oh[i] = gnt_vld && (gnt_idx == ID_W'(i));
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         rr_ptr_d = (gnt_idx == ID_W'(N_CORES - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // A capture on a core whose old sample is leaving this cycle simply
   // replaces it; otherwise a capture onto a pending core is dropped.
   always_comb begin
      for (int i = 0; i < N_CORES; i++) begin
         pending_d[i] = pending_q[i];
         hold_d[i]    = hold_q[i];
         ovr[i]       = 1'b0;
         if (cap[i]) begin
            if (pending_q[i] && !gnt_oh[i]) begin
               ovr[i] = 1'b1;
            end else begin
               hold_d[i]    = io_out_bus[DATA_W*i +: DATA_W];
               pending_d[i] = 1'b1;
            end
         end else if (gnt_oh[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      ovr_cnt = '0;
      for (int i = 0; i < N_CORES; i++) begin
         ovr_cnt = ovr_cnt + (ID_W+1)'(ovr[i]);
      end
      drop_sum  = {1'b0, drop_q} + 17'(ovr_cnt);
      drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overrun_d = overrun_q | ovr;
   end

   assign not_empty = (count_q != '0);
   assign push      = gnt_vld;
   assign pop       = not_empty && m_ready;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {gnt_idx, hold_q[gnt_idx]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         for (int i = 0; i < N_CORES; i++) begin
            hold_q[i] <= '0;
         end
         rr_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= '0;
         drop_q    <= '0;
      end else begin
         pending_q <= pending_d;
         hold_q    <= hold_d;
         rr_ptr_q  <= rr_ptr_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q   <= count_d;
         overrun_q <= overrun_d;
         drop_q    <= drop_d;
      end
   end

   // The head is gated by m_valid so the stream reads zero when empty,
   // including straight out of reset while the storage is uninitialised.
   assign head       = mem_q[rd_ptr_q];
   assign m_valid    = not_empty;
   assign m_data     = not_empty ? head[DATA_W-1:0] : '0;
   assign m_id       = not_empty ? head[ENT_W-1:DATA_W] : '0;
   assign fifo_level = count_q;
   assign overrun    = overrun_q;
   assign drop_count = drop_q;

endmodule
